// File: rtl/acc_writeback.sv
// acc_writeback: serialises accumulator rows into unified-buffer writes; define ACC_WB_RELU_EN for ReLU on the write path
module acc_writeback #(
  parameter int ROW_LEN = 2,
  parameter int DATA_W = 32,
  parameter int ADDR_W = 8,
  parameter int CNT_W = 8
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      start,
  input  logic [ADDR_W-1:0]         base_addr,
  input  logic [CNT_W-1:0]          num_rows,
  input  logic                      row_valid,
  output logic                      row_ready,
  input  logic [ROW_LEN*DATA_W-1:0] row_data,
  output logic                      wr_en,
  output logic [ADDR_W-1:0]         wr_addr,
  output logic [DATA_W-1:0]         wr_data,
  output logic                      busy,
  output logic                      done
);
  typedef enum logic [1:0] {IDLE, WAIT_ROW, WRITE, DONE} state_t;
  localparam int IW = $clog2(ROW_LEN + 1);
  localparam logic [IW-1:0] LAST = IW'(ROW_LEN);
  state_t state, state_n;
  logic [ADDR_W-1:0] addr, addr_n, wr_addr_n;
  logic [CNT_W-1:0] rem, rem_n;
  logic [IW-1:0] idx, idx_n;
  logic [ROW_LEN*DATA_W-1:0] row_buf, row_buf_n;
  logic [DATA_W-1:0] elem, elem_p, wr_data_n;
  logic load, emit, row_ready_n, wr_en_n, busy_n, done_n;
  // The first element is emitted straight from row_data on the handshake edge,
  // the rest from a buffer that shifts down one element per write; idx counts emitted elements.
  always_comb begin
    load = state == WAIT_ROW && row_valid && row_ready;
    emit = load || (state == WRITE && idx != LAST);
    elem = load ? row_data[DATA_W-1:0] : row_buf[DATA_W-1:0];
`ifdef ACC_WB_RELU_EN
    elem_p = elem[DATA_W-1] ? '0 : elem;
`else
    elem_p = elem;
`endif
    state_n = state;
    rem_n = rem;
    addr_n = emit ? addr + 1'b1 : addr;
    idx_n = load ? IW'(1) : emit ? idx + 1'b1 : idx;
    row_buf_n = load ? row_data >> DATA_W : emit ? row_buf >> DATA_W : row_buf;
    wr_en_n = emit;
    wr_addr_n = emit ? addr : wr_addr;
    wr_data_n = emit ? elem_p : wr_data;
    case (state)
      IDLE: if (start) begin
        addr_n = base_addr;
        rem_n = num_rows;
        state_n = num_rows == '0 ? DONE : WAIT_ROW;
      end
      WAIT_ROW: if (load) state_n = WRITE;
      WRITE: if (!emit) begin
        rem_n = rem - 1'b1;
        state_n = rem == CNT_W'(1) ? DONE : WAIT_ROW;
      end
      default: state_n = IDLE;
    endcase
    row_ready_n = state_n == WAIT_ROW;
    busy_n = state_n == WAIT_ROW || state_n == WRITE;
    done_n = state_n == DONE;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      addr <= '0;
      rem <= '0;
      idx <= '0;
      row_buf <= '0;
      row_ready <= 1'b0;
      wr_en <= 1'b0;
      wr_addr <= '0;
      wr_data <= '0;
      busy <= 1'b0;
      done <= 1'b0;
    end else begin
      state <= state_n;
      addr <= addr_n;
      rem <= rem_n;
      idx <= idx_n;
      row_buf <= row_buf_n;
      row_ready <= row_ready_n;
      wr_en <= wr_en_n;
      wr_addr <= wr_addr_n;
      wr_data <= wr_data_n;
      busy <= busy_n;
      done <= done_n;
    end
  end
endmodule

// File: tb/tb_acc_writeback.sv
// tb_acc_writeback: randomized jobs checked against a queue-based write model
module tb_acc_writeback;
  localparam int ROW_LEN = 2;
  localparam int DATA_W = 32;
  localparam int RW = ROW_LEN * DATA_W;
  typedef struct {logic [7:0] a; logic [31:0] d;} wr_t;
  logic clk = 0, reset = 1, start = 0, row_valid = 0;
  logic [7:0] base_addr = 0, num_rows = 0;
  logic [RW-1:0] row_data = '0;
  logic row_ready, wr_en, busy, done;
  logic [7:0] wr_addr;
  logic [31:0] wr_data;
  int n_chk = 0, n_fail = 0;
  wr_t exp_q[$];
  logic [RW-1:0] fixed_rows[$];
  logic [7:0] am;
  wr_t w;

  acc_writeback dut (
    .clk(clk), .reset(reset), .start(start), .base_addr(base_addr), .num_rows(num_rows),
    .row_valid(row_valid), .row_ready(row_ready), .row_data(row_data),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] model_w(input logic [31:0] v);
`ifdef ACC_WB_RELU_EN
    return $signed(v) < 0 ? 32'd0 : v;
`else
    return v;
`endif
  endfunction

  always @(negedge clk)
    if (wr_en) begin
      if (exp_q.size() == 0) check("spurious_wr", 1, 0);
      else begin
        w = exp_q.pop_front();
        check("wr_addr", 64'(wr_addr), 64'(w.a));
        check("wr_data", 64'(wr_data), 64'(w.d));
      end
    end

  task automatic job(input logic [7:0] base, input int n, input int gap_max);
    logic [RW-1:0] row;
    @(negedge clk);
    start = 1; base_addr = base; num_rows = 8'(n);
    @(negedge clk);
    start = 0; base_addr = 8'($urandom); num_rows = 8'($urandom);
    if (n == 0) begin
      check("zero_done", 64'(done), 1);
      check("zero_busy", 64'(busy), 0);
      check("zero_wr", 64'(wr_en), 0);
      @(negedge clk);
      check("zero_done_end", 64'(done), 0);
      return;
    end
    check("start_busy", 64'(busy), 1);
    check("start_ready", 64'(row_ready), 1);
    am = base;
    for (int r = 0; r < n; r++) begin
      row_valid = 0;
      repeat ($urandom_range(gap_max, 0)) begin
        @(negedge clk);
        check("gap_ready", 64'(row_ready), 1);
        check("gap_wr", 64'(wr_en), 0);
      end
      row = fixed_rows.size() != 0 ? fixed_rows.pop_front() : {$urandom, $urandom};
      row_valid = 1; row_data = row;
      for (int i = 0; i < ROW_LEN; i++) begin
        exp_q.push_back('{am, model_w(row[i*DATA_W +: DATA_W])});
        am++;
      end
      for (int i = 0; i < ROW_LEN; i++) begin
        @(negedge clk);
        row_valid = 1'($urandom); row_data = {$urandom, $urandom};
        start = ($urandom % 4) == 0; base_addr = 8'($urandom); num_rows = 8'($urandom);
        check("wr_en", 64'(wr_en), 1);
        check("wr_ready", 64'(row_ready), 0);
        check("wr_busy", 64'(busy), 1);
      end
      @(negedge clk);
      start = 0; row_valid = 0;
      if (r < n - 1) begin
        check("next_ready", 64'(row_ready), 1);
        check("next_wr", 64'(wr_en), 0);
      end else begin
        check("done", 64'(done), 1);
        check("done_busy", 64'(busy), 0);
        check("done_ready", 64'(row_ready), 0);
        check("done_wr", 64'(wr_en), 0);
        @(negedge clk);
        check("done_pulse", 64'(done), 0);
      end
    end
  endtask

  task automatic reset_mid_write();
    logic [RW-1:0] row;
    row = {$urandom, $urandom};
    @(negedge clk);
    start = 1; base_addr = 8'h40; num_rows = 2;
    @(negedge clk);
    start = 0; row_valid = 1; row_data = row;
    exp_q.push_back('{8'h40, model_w(row[31:0])});
    exp_q.push_back('{8'h41, model_w(row[63:32])});
    @(negedge clk);
    row_valid = 0;
    check("rst_first_wr", 64'(wr_en), 1);
    reset = 1;
    @(negedge clk);
    check("rst_wr_en", 64'(wr_en), 0);
    check("rst_busy", 64'(busy), 0);
    check("rst_ready", 64'(row_ready), 0);
    check("rst_wr_addr", 64'(wr_addr), 0);
    check("rst_done", 64'(done), 0);
    exp_q.delete();
    reset = 0;
    @(negedge clk);
    check("post_rst_wr", 64'(wr_en), 0);
    check("post_rst_busy", 64'(busy), 0);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    check("reset_ready", 64'(row_ready), 0);
    check("reset_wr_en", 64'(wr_en), 0);
    check("reset_wr_addr", 64'(wr_addr), 0);
    check("reset_wr_data", 64'(wr_data), 0);
    check("reset_busy", 64'(busy), 0);
    check("reset_done", 64'(done), 0);
    reset = 0;
    fixed_rows.push_back(64'h00000007_00000003);
    job(8'h10, 1, 0);
    fixed_rows.push_back(64'h00000002_00000001);
    fixed_rows.push_back(64'h00000004_00000003);
    fixed_rows.push_back(64'h00000006_00000005);
    job(8'h20, 3, 0);
    job(8'hFF, 1, 1);
    job(8'h33, 0, 0);
    fixed_rows.push_back(64'h00000005_FFFFFFFE);
    job(8'h50, 1, 0);
    reset_mid_write();
    job(8'hFE, 2, 1);
    for (int k = 0; k < 25; k++) job(8'($urandom), $urandom_range(4, 0), 2);
    @(negedge clk);
    check("drain", 64'(exp_q.size()), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
